// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex->seven-segment table for the scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Cathode bit positions within seg, packed as {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low patterns, indexed by nibble value
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low segment pattern lookup
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit seven-segment scan driver with frame-synchronous updates
// Optional anti-ghosting dark gap at slot start: define SEG7_SCAN_BLANK_GAP_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int GAP_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [2:0]              sel,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8 || GAP_CYCLES < 0) begin : g_bad_params
            $error("seg7_scan_ctrl: illegal parameter combination");
        end
    endgenerate

    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] act_hex, pend_hex;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic                    pend_valid;

    logic                    tick, wrap, commit, in_gap;
    logic [CW-1:0]           cnt_next;
    logic [2:0]              sel_next;
    logic [4*NUM_DIGITS-1:0] hex_next;
    logic [NUM_DIGITS-1:0]   dp_next, blank_next;
    logic [31:0]             hex_x;
    logic [7:0]              dp_x, blank_x;
    logic [6:0]              lut_seg;

    assign tick     = (cnt == CW'(DIV - 1));
    assign wrap     = tick && (sel == 3'(NUM_DIGITS - 1));
    assign commit   = wrap && pend_valid;
    assign cnt_next = tick ? '0 : cnt + CW'(1);
    assign sel_next = wrap ? 3'd0 : (tick ? sel + 3'd1 : sel);

    // Output registers are fed from next-state values so sel, seg and dp move together
    assign hex_next   = commit ? pend_hex   : act_hex;
    assign dp_next    = commit ? pend_dp    : act_dp;
    assign blank_next = commit ? pend_blank : act_blank;

    assign hex_x   = 32'(hex_next);
    assign dp_x    = 8'(dp_next);
    assign blank_x = 8'(blank_next);

`ifdef SEG7_SCAN_BLANK_GAP_EN
    assign in_gap = (int'(cnt_next) < GAP_CYCLES);
`else
    assign in_gap = 1'b0;
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (hex_x[{sel_next, 2'b00} +: 4]),
        .seg    (lut_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= 3'd0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            act_hex    <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            pend_hex   <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_valid <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            sel        <= sel_next;
            frame_done <= wrap;

            if (commit) begin
                act_hex   <= pend_hex;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end

            // A load coinciding with a commit keeps pend_valid set for the next frame
            if (load) begin
                pend_hex   <= hex_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            pend_valid <= load | (pend_valid & ~commit);

            seg <= (in_gap || blank_x[sel_next]) ? SEG_OFF : lut_seg;
            dp  <= in_gap | ~dp_x[sel_next] | blank_x[sel_next];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed table-driven bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dpm;
        logic [3:0]  blk;
        logic [27:0] exp_seg;   // {sel3, sel2, sel1, sel0}
        logic [3:0]  exp_dp;    // active-low, bit k for sel k
    } vec_t;

    vec_t vecs [4];

    seg7_scan_ctrl #(
        .CLK_HZ     (8),
        .REFRESH_HZ (2),
        .NUM_DIGITS (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("frame_sync", 32'(frame_done), 32'd1);
    endtask

    // Entered on the first cycle of a frame; leaves on its last cycle
    task automatic check_frame(input logic [27:0] es, input logic [3:0] ed);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                chk("slot_sel", 32'(sel), 32'(s));
                if (c == 0) begin
`ifdef SEG7_SCAN_BLANK_GAP_EN
                    chk("gap_seg", 32'(seg), 32'h7F);
                    chk("gap_dp", 32'(dp), 32'd1);
`else
                    chk("first_seg", 32'(seg), 32'(es[s*7 +: 7]));
                    chk("first_dp", 32'(dp), 32'(ed[s]));
`endif
                end
                if (c == 3) begin
                    chk("slot_seg", 32'(seg), 32'(es[s*7 +: 7]));
                    chk("slot_dp", 32'(dp), 32'(ed[s]));
                end
            end
        end
    endtask

    // Called right after reset release on a negedge: k-th edge gives sel=(k/4)%4
    task automatic free_run_dark();
        int fd_count = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk("run_sel", 32'(sel), 32'((k / 4) % 4));
            chk("run_fd", 32'(frame_done), 32'((k % 16) == 0));
            chk("dark_seg", 32'(seg), 32'h7F);
            chk("dark_dp", 32'(dp), 32'd1);
            if (frame_done) fd_count++;
        end
        chk("fd_count", 32'(fd_count), 32'd3);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h1234, 4'b0010, 4'b1000, {7'h7F, 7'h24, 7'h30, 7'h19}, 4'b1101};
        vecs[2] = '{16'h80AF, 4'b1111, 4'b0000, {7'h00, 7'h40, 7'h08, 7'h0E}, 4'b0000};
        vecs[3] = '{16'h5C6E, 4'b0001, 4'b0101, {7'h12, 7'h7F, 7'h02, 7'h7F}, 4'b1111};

        #2 reset = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        free_run_dark();

        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            do_load(vecs[i].hex, vecs[i].dpm, vecs[i].blk);
            if (i == 0) begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("pending_dark", 32'(seg), 32'h7F);
                end
            end
            wait_frame();
            check_frame(vecs[i].exp_seg, vecs[i].exp_dp);
        end

        // Load racing the commit: old pending shows first, new data one frame later
        repeat (2) @(negedge clk);
        do_load(16'h8888, 4'b0000, 4'b0000);
        repeat (13) @(negedge clk);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        chk("race_fd1", 32'(frame_done), 32'd1);
        check_frame({7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111);
        @(negedge clk);
        chk("race_fd2", 32'(frame_done), 32'd1);
        check_frame({7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1111);

        // Reset in the middle of a lit slot abandons the frame
        repeat (6) @(negedge clk);
        chk("pre_rst_sel", 32'(sel), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        free_run_dark();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
